// File: rtl/wb_trace_buffer_pkg.sv
// Shared types and constants for the writeback trace buffer.
// Includes the stream FSM encoding and the saturating drop counter helper.
package wb_trace_buffer_pkg;

  localparam int TRACE_W = 64;
  localparam int DROP_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_PC   = 2'd1,
    ST_SEND_DATA = 2'd2
  } state_e;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/wb_trace_buffer_fifo.sv
// Synchronous FIFO with an asynchronous active-high reset.
// The read data shows the head entry combinationally; a push while full succeeds only when a pop happens on the same edge.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures {PC, writeback data} pairs and streams each one as a PC word followed by a data word.
// A stalled sink never back-pressures the CPU; captures that find no room are dropped and counted.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter bit CHANGE_ONLY = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       PCResult,
  input  logic [31:0]       WbData,
  input  logic              WbValid,
  output logic [31:0]       OutData,
  output logic              OutIsPC,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [AW:0]       Count,
  output logic              Overflow,
  output logic [DROP_W-1:0] DropCount,
  input  logic              ClearOverflow
);

  logic [TRACE_W-1:0] cap_pair, fifo_rdata;
  logic [TRACE_W-1:0] last_q, last_d;
  logic               first_q, first_d;
  logic               want, fifo_push, fifo_pop, fifo_full, fifo_empty, drop, load;
  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic               out_is_pc_q, out_is_pc_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [31:0]        hold_data_q, hold_data_d;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_count_q, drop_count_d;

  assign cap_pair = {PCResult, WbData};

  sync_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .W    (TRACE_W)
  ) u_fifo (
    .clk  (Clk),
    .rst  (Reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(cap_pair),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(Count)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_is_pc_d = out_is_pc_q;
    out_data_d  = out_data_q;
    hold_data_d = hold_data_q;
    fifo_pop    = 1'b0;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_SEND_PC: begin
        if (OutReady) begin
          state_d     = ST_SEND_DATA;
          out_is_pc_d = 1'b0;
          out_data_d  = hold_data_q;
        end
      end
      ST_SEND_DATA: begin
        if (OutReady) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_is_pc_d = 1'b0;
            out_data_d  = '0;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_is_pc_d = 1'b0;
        out_data_d  = '0;
      end
    endcase
    // Loading the next entry happens from IDLE or straight after a data handshake.
    if (load) begin
      fifo_pop    = 1'b1;
      state_d     = ST_SEND_PC;
      out_valid_d = 1'b1;
      out_is_pc_d = 1'b1;
      out_data_d  = fifo_rdata[TRACE_W-1:32];
      hold_data_d = fifo_rdata[31:0];
    end
  end

  always_comb begin
    want         = WbValid && (!CHANGE_ONLY || first_q || (cap_pair != last_q));
    fifo_push    = want && (!fifo_full || fifo_pop);
    drop         = want && !fifo_push;
    first_d      = fifo_push ? 1'b0 : first_q;
    last_d       = fifo_push ? cap_pair : last_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (ClearOverflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
    // A drop in the same cycle as a clear must still be recorded.
    if (drop) begin
      overflow_d   = 1'b1;
      drop_count_d = sat_inc(ClearOverflow ? '0 : drop_count_q);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_is_pc_q  <= 1'b0;
      out_data_q   <= '0;
      hold_data_q  <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      first_q      <= 1'b1;
      last_q       <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_is_pc_q  <= out_is_pc_d;
      out_data_q   <= out_data_d;
      hold_data_q  <= hold_data_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      first_q      <= first_d;
      last_q       <= last_d;
    end
  end

  assign OutValid  = out_valid_q;
  assign OutIsPC   = out_is_pc_q;
  assign OutData   = out_data_q;
  assign Overflow  = overflow_q;
  assign DropCount = drop_count_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: a queue-based model of the capture/stream rules checked every cycle,
// plus directed scenarios with literal expectations and a randomized run.
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_result = '0, wb_data = '0;
  logic        wb_valid = 1'b0, out_ready = 1'b0, clear_overflow = 1'b0;

  logic [31:0] out_data0, out_data1;
  logic        out_is_pc0, out_is_pc1, out_valid0, out_valid1;
  logic [AW:0] count0, count1;
  logic        overflow0, overflow1;
  logic [15:0] drop_count0, drop_count1;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  bit mon_en = 1'b0;

  logic [32:0] mon0[$];
  logic [32:0] mon1[$];

  // Behavioural model of the plain (CHANGE_ONLY=0) instance
  logic [63:0] mq[$];
  logic [63:0] m_cur = '0;
  int          m_wl = 0;
  bit          m_ovf = 1'b0;
  int          m_drops = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .CHANGE_ONLY(1'b0)) dut0 (
    .Clk(clk), .Reset(reset), .PCResult(pc_result), .WbData(wb_data), .WbValid(wb_valid),
    .OutData(out_data0), .OutIsPC(out_is_pc0), .OutValid(out_valid0), .OutReady(out_ready),
    .Count(count0), .Overflow(overflow0), .DropCount(drop_count0), .ClearOverflow(clear_overflow)
  );

  wb_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .CHANGE_ONLY(1'b1)) dut1 (
    .Clk(clk), .Reset(reset), .PCResult(pc_result), .WbData(wb_data), .WbValid(wb_valid),
    .OutData(out_data1), .OutIsPC(out_is_pc1), .OutValid(out_valid1), .OutReady(out_ready),
    .Count(count1), .Overflow(overflow1), .DropCount(drop_count1), .ClearOverflow(clear_overflow)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // m_wl counts words of the current entry still to be sent: 2 = PC showing, 1 = data showing.
  always @(posedge clk or posedge reset) begin : model
    bit          full_b, pop_b, drop_b;
    logic [63:0] popped;
    if (reset) begin
      mq.delete();
      m_wl    = 0;
      m_cur   = '0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      popped = '0;
      full_b = (mq.size() == DEPTH);
      pop_b  = (mq.size() > 0) && ((m_wl == 0) || (m_wl == 1 && out_ready));
      drop_b = wb_valid && full_b && !pop_b;
      if (pop_b) popped = mq.pop_front();
      if (wb_valid && !drop_b) mq.push_back({pc_result, wb_data});
      if (clear_overflow) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
      if (drop_b) begin
        m_ovf   = 1'b1;
        m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
      end
      if (pop_b) begin
        m_cur = popped;
        m_wl  = 2;
      end else if (m_wl > 0 && out_ready) begin
        m_wl = m_wl - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && cmp_en) begin
      checkOutput("model_count", 64'(count0), 64'(mq.size()));
      checkOutput("model_overflow", 64'(overflow0), 64'(m_ovf));
      checkOutput("model_dropcount", 64'(drop_count0), 64'(m_drops));
      checkOutput("model_valid", 64'(out_valid0), 64'(m_wl > 0));
      if (m_wl > 0) begin
        checkOutput("model_ispc", 64'(out_is_pc0), 64'(m_wl == 2));
        checkOutput("model_data", 64'(out_data0), 64'((m_wl == 2) ? m_cur[63:32] : m_cur[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (out_valid0 && out_ready) mon0.push_back({out_is_pc0, out_data0});
      if (out_valid1 && out_ready) mon1.push_back({out_is_pc1, out_data1});
    end
  end

  task automatic applyStimulus(input bit v, input logic [31:0] p, input logic [31:0] d, input bit r, input bit c);
    wb_valid       = v;
    pc_result      = p;
    wb_data        = d;
    out_ready      = r;
    clear_overflow = c;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    wb_valid = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
    pc_result = '0; wb_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drainModel(input int budget, input bit toggle);
    int n;
    bit r;
    n = 0;
    r = 1'b1;
    while ((m_wl != 0 || mq.size() != 0) && n < budget) begin
      applyStimulus(1'b0, '0, '0, r, 1'b0);
      if (toggle) r = ~r;
      n++;
    end
    checkOutput("drain_in_budget", 64'(n < budget), 64'd1);
  endtask

  initial begin
    logic [32:0] exp4[4];
    logic [32:0] exp6[8];
    bit r;
    int p_ready;

    cmp_en = 1'b1;

    // Scenario 1: single entry, sink always ready
    doReset();
    checkOutput("rst_valid", 64'(out_valid0), 64'd0);
    checkOutput("rst_ispc", 64'(out_is_pc0), 64'd0);
    checkOutput("rst_data", 64'(out_data0), 64'd0);
    checkOutput("rst_count", 64'(count0), 64'd0);
    checkOutput("rst_overflow", 64'(overflow0), 64'd0);
    checkOutput("rst_drops", 64'(drop_count0), 64'd0);
    applyStimulus(1'b1, 32'h40, 32'h5, 1'b1, 1'b0);
    checkOutput("s1_count_after_cap", 64'(count0), 64'd1);
    checkOutput("s1_valid_after_cap", 64'(out_valid0), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("s1_pc_valid", 64'(out_valid0), 64'd1);
    checkOutput("s1_pc_ispc", 64'(out_is_pc0), 64'd1);
    checkOutput("s1_pc_word", 64'(out_data0), 64'h40);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("s1_data_ispc", 64'(out_is_pc0), 64'd0);
    checkOutput("s1_data_word", 64'(out_data0), 64'h5);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("s1_idle_valid", 64'(out_valid0), 64'd0);

    // Scenario 2: fill with the sink stalled, then overflow and clear
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 32'h100 + 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
    checkOutput("s2_count_full", 64'(count0), 64'd16);
    checkOutput("s2_no_drops", 64'(drop_count0), 64'd0);
    checkOutput("s2_held_pc", 64'(out_data0), 64'h100);
    applyStimulus(1'b1, 32'h200, 32'h99, 1'b0, 1'b0);
    checkOutput("s2_overflow", 64'(overflow0), 64'd1);
    checkOutput("s2_dropcount", 64'(drop_count0), 64'd1);
    checkOutput("s2_count_still", 64'(count0), 64'd16);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("s2_clr_overflow", 64'(overflow0), 64'd0);
    checkOutput("s2_clr_dropcount", 64'(drop_count0), 64'd0);

    // Scenario 3: pop from SEND_DATA makes room for a same-edge capture
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("s3_data_word", 64'(out_data0), 64'h1000);
    applyStimulus(1'b1, 32'h300, 32'h3003, 1'b1, 1'b0);
    checkOutput("s3_count_16", 64'(count0), 64'd16);
    checkOutput("s3_no_drop", 64'(drop_count0), 64'd0);
    checkOutput("s3_next_pc", 64'(out_data0), 64'h104);
    applyStimulus(1'b1, 32'h401, 32'h1, 1'b0, 1'b0);
    checkOutput("s3_drop1", 64'(drop_count0), 64'd1);
    applyStimulus(1'b1, 32'h402, 32'h2, 1'b0, 1'b1);
    checkOutput("s3_drop_wins_ovf", 64'(overflow0), 64'd1);
    checkOutput("s3_drop_wins_cnt", 64'(drop_count0), 64'd1);
    applyStimulus(1'b1, 32'h403, 32'h3, 1'b0, 1'b0);
    checkOutput("s3_drop2", 64'(drop_count0), 64'd2);
    drainModel(200, 1'b0);

    // Scenario 4: change-only filtering on the second instance
    doReset();
    mon0.delete(); mon1.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h8, 32'h7, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hC, 32'h7, 1'b1, 1'b0);
    drainModel(100, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    mon_en = 1'b0;
    exp4[0] = {1'b1, 32'h8}; exp4[1] = {1'b0, 32'h7};
    exp4[2] = {1'b1, 32'hC}; exp4[3] = {1'b0, 32'h7};
    checkOutput("s4_co_words", 64'(mon1.size()), 64'd4);
    for (int i = 0; i < 4 && i < mon1.size(); i++) checkOutput("s4_co_word", 64'(mon1[i]), 64'(exp4[i]));
    checkOutput("s4_plain_words", 64'(mon0.size()), 64'd8);
    checkOutput("s4_co_idle", 64'(out_valid1), 64'd0);

    // Scenario 5: asynchronous reset while holding a PC word
    doReset();
    applyStimulus(1'b1, 32'h50, 32'h55, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("s5_sendpc_valid", 64'(out_valid0), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("s5_async_valid", 64'(out_valid0), 64'd0);
    checkOutput("s5_async_count", 64'(count0), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(1'b1, 32'h60, 32'h66, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("s5_after_pc", 64'(out_data0), 64'h60);
    checkOutput("s5_after_ispc", 64'(out_is_pc0), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("s5_after_data", 64'(out_data0), 64'h66);

    // Scenario 6: sink ready toggling every cycle
    doReset();
    mon0.delete();
    mon_en = 1'b1;
    r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h700 + 32'(i * 4), 32'h7000 + 32'(i), r, 1'b0);
      r = ~r;
    end
    drainModel(100, 1'b1);
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp6[2*i]   = {1'b1, 32'h700 + 32'(i * 4)};
      exp6[2*i+1] = {1'b0, 32'h7000 + 32'(i)};
    end
    checkOutput("s6_words", 64'(mon0.size()), 64'd8);
    for (int i = 0; i < 8 && i < mon0.size(); i++) checkOutput("s6_word", 64'(mon0[i]), 64'(exp6[i]));

    // Randomized run with varying sink throughput
    doReset();
    for (int n = 0; n < 3000; n++) begin
      case ((n / 300) % 4)
        0: p_ready = 90;
        1: p_ready = 10;
        2: p_ready = 50;
        default: p_ready = 0;
      endcase
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                    ($urandom_range(0, 99) < p_ready), ($urandom_range(0, 99) < 3));
    end
    drainModel(300, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
